mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-port synchronous RAM.
// Each granted access takes IDLE -> ACCESS -> DATA, with a one-cycle ack on return to IDLE.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              v_req,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [DATA_W-1:0] v_wdata,
    output logic              v_ack,
    output logic [DATA_W-1:0] v_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA
    } state_t;

    localparam logic GRANT_C = 1'b0;
    localparam logic GRANT_V = 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memDin_q, memDin_d;
    logic              memWe_q, memWe_d;
    logic              txnWe_q, txnWe_d;
    logic              owner_q, owner_d;
    logic              lastGrant_q, lastGrant_d;
    logic              cAck_q, cAck_d;
    logic              vAck_q, vAck_d;
    logic [DATA_W-1:0] cRdata_q, cRdata_d;
    logic [DATA_W-1:0] vRdata_q, vRdata_d;

    logic cEligible;
    logic vEligible;
    logic winner;

    // A requester still showing its ack this cycle is finishing, not asking again.
    assign cEligible = c_req & ~cAck_q;
    assign vEligible = v_req & ~vAck_q;
    assign winner    = (cEligible & vEligible) ? ~lastGrant_q : vEligible;

    always_comb begin
        state_d     = state_q;
        memAddr_d   = memAddr_q;
        memDin_d    = memDin_q;
        memWe_d     = 1'b0;
        txnWe_d     = txnWe_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        cAck_d      = 1'b0;
        vAck_d      = 1'b0;
        cRdata_d    = cRdata_q;
        vRdata_d    = vRdata_q;

        case (state_q)
            IDLE: begin
                if (cEligible | vEligible) begin
                    state_d   = ACCESS;
                    owner_d   = winner;
                    memAddr_d = (winner == GRANT_V) ? v_addr  : c_addr;
                    memDin_d  = (winner == GRANT_V) ? v_wdata : c_wdata;
                    memWe_d   = (winner == GRANT_V) ? v_we    : c_we;
                    txnWe_d   = (winner == GRANT_V) ? v_we    : c_we;
                end
            end
            ACCESS: begin
                state_d = DATA;
            end
            DATA: begin
                state_d     = IDLE;
                lastGrant_d = owner_q;
                if (owner_q == GRANT_V) begin
                    vAck_d = 1'b1;
                    if (!txnWe_q) begin
                        vRdata_d = mem_dout;
                    end
                end else begin
                    cAck_d = 1'b1;
                    if (!txnWe_q) begin
                        cRdata_d = mem_dout;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset clears everything, including a write pulse already on the RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            memAddr_q   <= '0;
            memDin_q    <= '0;
            memWe_q     <= 1'b0;
            txnWe_q     <= 1'b0;
            owner_q     <= GRANT_C;
            lastGrant_q <= GRANT_V;
            cAck_q      <= 1'b0;
            vAck_q      <= 1'b0;
            cRdata_q    <= '0;
            vRdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            memAddr_q   <= memAddr_d;
            memDin_q    <= memDin_d;
            memWe_q     <= memWe_d;
            txnWe_q     <= txnWe_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            cAck_q      <= cAck_d;
            vAck_q      <= vAck_d;
            cRdata_q    <= cRdata_d;
            vRdata_q    <= vRdata_d;
        end
    end

    assign mem_addr = memAddr_q;
    assign mem_din  = memDin_q;
    assign mem_we   = memWe_q;
    assign c_ack    = cAck_q;
    assign v_ack    = vAck_q;
    assign c_rdata  = cRdata_q;
    assign v_rdata  = vRdata_q;
    assign busy     = (state_q != IDLE);

endmodule
